// File: rtl/tinyfpga_cfg_loader_if.sv
// Programming-port interface of the tinyFPGA configuration loader.
//   prog_en    : programming mode request            (master -> slave)
//   prog_valid : prog_in carries a beat this cycle   (master -> slave)
//   prog_in    : LANES-wide configuration beat       (master -> slave)
//   prog_out   : chain tail for daisy-chaining       (slave -> master)
interface tinyfpga_cfg_loader_if #(
  parameter int LANES = 1
);
  logic             prog_en;
  logic             prog_valid;
  logic [LANES-1:0] prog_in;
  logic [LANES-1:0] prog_out;

  modport master (
    output prog_en,
    output prog_valid,
    output prog_in,
    input  prog_out
  );

  modport slave (
    input  prog_en,
    input  prog_valid,
    input  prog_in,
    output prog_out
  );
endinterface

// File: rtl/tinyfpga_cfg_loader.sv
// Configuration front-end for the tinyFPGA fabric.
// A LANES-wide serial bitstream is shifted into a CFG_BITS chain, then checked
// against a trailing column-parity beat. Only a verified image is copied to the
// shadow configuration cfg_out. The fabric is held in reset and its user inputs
// are gated to zero whenever the loader is not in RUN.
// Ports:
//   clk, rst   : single clock, synchronous active-high reset
//   prog       : programming port (prog_en/prog_valid/prog_in in, prog_out out)
//   fpga_in    : user input pins
//   cfg_out    : committed configuration to the fabric
//   fabric_in  : user inputs forwarded in RUN, zero otherwise
//   fabric_rst : fabric reset, high whenever not in RUN
//   cfg_done   : a verified image is held in cfg_out
//   cfg_err    : last load failed parity or was aborted
module tinyfpga_cfg_loader #(
  parameter int N_IN     = 5,
  parameter int LANES    = 1,
  parameter int CFG_BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  tinyfpga_cfg_loader_if.slave prog,
  input  logic [N_IN-1:0]     fpga_in,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic [N_IN-1:0]     fabric_in,
  output logic                fabric_rst,
  output logic                cfg_done,
  output logic                cfg_err
);

  // CFG_BITS must be a multiple of LANES.
  localparam int BEATS = CFG_BITS / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DONE,
    ERR,
    RUN
  } state_t;

  state_t              state;
  state_t              ns;
  logic [CFG_BITS-1:0] cfg_sr;
  logic [CNT_W-1:0]    count;
  logic [LANES-1:0]    par;
  logic                data_beat;
  logic                check_beat;

  // Beat classification inside LOAD; an abort (prog_en low) masks both.
  assign data_beat  = (state == LOAD) && prog.prog_en && prog.prog_valid
                      && (count < CNT_W'(BEATS));
  assign check_beat = (state == LOAD) && prog.prog_en && prog.prog_valid
                      && (count == CNT_W'(BEATS));

  // NOTE: ns gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ns = state;
    case (state)
      IDLE: begin
        if (prog.prog_en)  ns = LOAD;
        else if (cfg_done) ns = RUN;
      end
      LOAD: begin
        if (!prog.prog_en)   ns = IDLE;
        else if (check_beat) ns = (prog.prog_in == par) ? DONE : ERR;
      end
      DONE:    if (!prog.prog_en) ns = RUN;
      ERR:     if (!prog.prog_en) ns = IDLE;
      RUN:     if (prog.prog_en)  ns = LOAD;
      default: ns = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      // NOTE: the chain is cleared by reset because prog_out streams its
      // contents out; an unreset chain would leak X onto the daisy chain.
      cfg_sr        <= '0;
      cfg_out       <= '0;
      count         <= '0;
      par           <= '0;
      prog.prog_out <= '0;
      fabric_in     <= '0;
      fabric_rst    <= 1'b1;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state      <= ns;
      // Fabric controls follow the next state so they switch with the state.
      fabric_rst <= (ns != RUN);
      fabric_in  <= (ns == RUN) ? fpga_in : '0;

      // Entering LOAD starts a fresh image; cfg_sr is deliberately kept so
      // the previous image streams out of prog_out.
      if (state != LOAD && ns == LOAD) begin
        count   <= '0;
        par     <= '0;
        cfg_err <= 1'b0;
      end

      if (state == LOAD && !prog.prog_en) begin
        cfg_err <= 1'b1;
      end

      if (data_beat) begin
        cfg_sr        <= (cfg_sr << LANES) | CFG_BITS'(prog.prog_in);
        prog.prog_out <= cfg_sr[CFG_BITS-1 -: LANES];
        par           <= par ^ prog.prog_in;
        count         <= count + 1'b1;
      end

      // Check beat is compared, never shifted.
      if (check_beat) begin
        if (prog.prog_in == par) begin
          cfg_out  <= cfg_sr;
          cfg_done <= 1'b1;
        end else begin
          cfg_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyfpga_cfg_loader.sv
module tb_tinyfpga_cfg_loader;

  localparam int N_IN     = 5;
  localparam int LANES    = 1;
  localparam int CFG_BITS = 64;

  localparam logic [63:0] IMG_GOOD  = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] IMG_BAD   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IMG_DAISY = 64'hA5A5_0F0F_1234_8765;

  logic                clk;
  logic                rst;
  logic [N_IN-1:0]     fpga_in;
  logic [CFG_BITS-1:0] cfg_out;
  logic [N_IN-1:0]     fabric_in;
  logic                fabric_rst;
  logic                cfg_done;
  logic                cfg_err;

  tinyfpga_cfg_loader_if #(.LANES(LANES)) prog ();

  tinyfpga_cfg_loader #(
    .N_IN    (N_IN),
    .LANES   (LANES),
    .CFG_BITS(CFG_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog      (prog.slave),
    .fpga_in   (fpga_in),
    .cfg_out   (cfg_out),
    .fabric_in (fabric_in),
    .fabric_rst(fabric_rst),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Bench-side copy of the shift chain and the last prog_out value.
  logic [63:0] model_sr;
  logic        exp_po;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Plain 64-beat load plus check beat; prog_out checked on every data beat.
  task automatic load_image(input logic [63:0] img, input bit bad_par,
                            input bit stalls);
    prog.prog_en    = 1'b1;
    prog.prog_valid = 1'b0;
    step();
    vectors++;
    if (fabric_rst !== 1'b1 || fabric_in !== '0) begin
      miscompares++;
      $display("FAIL load_entry_fabric: rst=%b in=%h expected rst=1 in=00",
               fabric_rst, fabric_in);
    end
    for (int k = 0; k < 64; k++) begin
      if (stalls) begin
        int gap;
        gap = $urandom_range(0, 3);
        prog.prog_valid = 1'b0;
        prog.prog_in    = ~img[63-k];
        for (int g = 0; g < gap; g++) step();
      end
      prog.prog_valid = 1'b1;
      prog.prog_in    = img[63-k];
      exp_po          = model_sr[63];
      model_sr        = {model_sr[62:0], img[63-k]};
      step();
      vectors++;
      if (prog.prog_out !== exp_po) begin
        miscompares++;
        $display("FAIL prog_out_beat%0d: got %b expected %b", k, prog.prog_out, exp_po);
      end
    end
    if (stalls) begin
      prog.prog_valid = 1'b0;
      step();
      step();
    end
    prog.prog_valid = 1'b1;
    prog.prog_in    = (^img) ^ bad_par;
    step();
    prog.prog_valid = 1'b0;
  endtask

  // Beats offered in DONE/ERR must not move the chain or the shadow config.
  task automatic send_ignored(input logic [63:0] exp_cfg, input string tag);
    for (int k = 0; k < 3; k++) begin
      prog.prog_valid = 1'b1;
      prog.prog_in    = k[0];
      step();
    end
    prog.prog_valid = 1'b0;
    vectors++;
    if (cfg_out !== exp_cfg || prog.prog_out !== exp_po) begin
      miscompares++;
      $display("FAIL %s_ignored: cfg_out=%h prog_out=%b expected %h %b",
               tag, cfg_out, prog.prog_out, exp_cfg, exp_po);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    prog.prog_en    = 1'b0;
    prog.prog_valid = 1'b0;
    prog.prog_in    = '0;
    fpga_in         = 5'h1F;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (cfg_out !== '0 || prog.prog_out !== '0 || fabric_rst !== 1'b1 ||
        fabric_in !== '0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: cfg_out=%h po=%b frst=%b fin=%h done=%b err=%b expected 0 0 1 0 0 0",
               cfg_out, prog.prog_out, fabric_rst, fabric_in, cfg_done, cfg_err);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (fabric_rst !== 1'b1 || fabric_in !== '0 || cfg_done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold_%0d: frst=%b fin=%h done=%b expected 1 00 0",
                 c, fabric_rst, fabric_in, cfg_done);
      end
    end
    model_sr = '0;
    exp_po   = 1'b0;
  endtask

  task automatic test_good_load();
    load_image(IMG_GOOD, 1'b0, 1'b0);
    vectors++;
    if (cfg_out !== IMG_GOOD || cfg_done !== 1'b1 || cfg_err !== 1'b0 ||
        fabric_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL good_commit: cfg_out=%h done=%b err=%b frst=%b expected %h 1 0 1",
               cfg_out, cfg_done, cfg_err, fabric_rst, IMG_GOOD);
    end
    send_ignored(IMG_GOOD, "done");
    fpga_in      = 5'h15;
    prog.prog_en = 1'b0;
    step();
    vectors++;
    if (fabric_rst !== 1'b0 || fabric_in !== 5'h15) begin
      miscompares++;
      $display("FAIL good_run: frst=%b fin=%h expected 0 15", fabric_rst, fabric_in);
    end
  endtask

  task automatic test_bad_parity();
    load_image(IMG_BAD, 1'b1, 1'b0);
    vectors++;
    if (cfg_err !== 1'b1 || cfg_out !== IMG_GOOD || cfg_done !== 1'b1 ||
        fabric_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_parity: err=%b cfg_out=%h done=%b frst=%b expected 1 %h 1 1",
               cfg_err, cfg_out, cfg_done, fabric_rst, IMG_GOOD);
    end
    send_ignored(IMG_GOOD, "err");
    prog.prog_en = 1'b0;
    step();
    vectors++;
    if (fabric_rst !== 1'b1 || fabric_in !== '0) begin
      miscompares++;
      $display("FAIL bad_idle: frst=%b fin=%h expected 1 00", fabric_rst, fabric_in);
    end
    step();
    vectors++;
    if (fabric_rst !== 1'b0 || fabric_in !== 5'h15 || cfg_out !== IMG_GOOD ||
        cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_run_old_image: frst=%b fin=%h cfg_out=%h err=%b expected 0 15 %h 1",
               fabric_rst, fabric_in, cfg_out, cfg_err, IMG_GOOD);
    end
  endtask

  task automatic test_abort();
    prog.prog_en    = 1'b1;
    prog.prog_valid = 1'b0;
    step();
    for (int k = 0; k < 21; k++) begin
      prog.prog_valid = 1'b1;
      prog.prog_in    = IMG_BAD[63-k];
      exp_po          = model_sr[63];
      model_sr        = {model_sr[62:0], IMG_BAD[63-k]};
      step();
    end
    // prog_en drops with a valid beat in the same cycle; the beat is lost.
    prog.prog_en    = 1'b0;
    prog.prog_valid = 1'b1;
    prog.prog_in    = ~model_sr[63];
    step();
    prog.prog_valid = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1 || fabric_rst !== 1'b1 || cfg_out !== IMG_GOOD ||
        cfg_done !== 1'b1 || prog.prog_out !== exp_po) begin
      miscompares++;
      $display("FAIL abort: err=%b frst=%b cfg_out=%h done=%b po=%b expected 1 1 %h 1 %b",
               cfg_err, fabric_rst, cfg_out, cfg_done, prog.prog_out, IMG_GOOD, exp_po);
    end
    step();
    vectors++;
    if (fabric_rst !== 1'b0 || cfg_out !== IMG_GOOD) begin
      miscompares++;
      $display("FAIL abort_run: frst=%b cfg_out=%h expected 0 %h",
               fabric_rst, cfg_out, IMG_GOOD);
    end
  endtask

  task automatic test_stalls();
    load_image(IMG_BAD, 1'b0, 1'b1);
    vectors++;
    if (cfg_out !== IMG_BAD || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_commit: cfg_out=%h done=%b err=%b expected %h 1 0",
               cfg_out, cfg_done, cfg_err, IMG_BAD);
    end
    prog.prog_en = 1'b0;
    step();
  endtask

  // Chain holds IMG_BAD here, so beat i of this load must show IMG_BAD[63-i].
  task automatic test_daisy_chain();
    load_image(IMG_DAISY, 1'b0, 1'b0);
    vectors++;
    if (cfg_out !== IMG_DAISY) begin
      miscompares++;
      $display("FAIL daisy_commit: cfg_out=%h expected %h", cfg_out, IMG_DAISY);
    end
    prog.prog_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    prog.prog_en    = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      prog.prog_valid = 1'b1;
      prog.prog_in    = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst             = 1'b0;
    prog.prog_en    = 1'b0;
    prog.prog_valid = 1'b0;
    vectors++;
    if (cfg_out !== '0 || cfg_done !== 1'b0 || cfg_err !== 1'b0 ||
        fabric_rst !== 1'b1 || prog.prog_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_load: cfg_out=%h done=%b err=%b frst=%b po=%b expected 0 0 0 1 0",
               cfg_out, cfg_done, cfg_err, fabric_rst, prog.prog_out);
    end
    step();
    vectors++;
    if (fabric_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_run: frst=%b expected 1", fabric_rst);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_parity();
    test_abort();
    test_stalls();
    test_daisy_chain();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
